// File: rtl/axi_stream_fifo_pkg.sv
// Shared definitions for the AXI4-Stream FIFO: packed payload width and field offsets.
package axi_stream_fifo_pkg;

  localparam int unsigned DEPTH_LOG2_MIN = 32'd1;
  localparam int unsigned DEPTH_LOG2_MAX = 32'd12;

  // Payload packing, LSB first: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
  function automatic int unsigned axis_payload_w(input int unsigned byte_width,
                                                 input int unsigned id_width,
                                                 input int unsigned dest_width,
                                                 input int unsigned user_width);
    return 32'd10 * byte_width + 32'd1 + id_width + dest_width + user_width;
  endfunction

  function automatic int unsigned axis_strb_lsb(input int unsigned byte_width);
    return 32'd8 * byte_width;
  endfunction

  function automatic int unsigned axis_keep_lsb(input int unsigned byte_width);
    return 32'd9 * byte_width;
  endfunction

  function automatic int unsigned axis_last_bit(input int unsigned byte_width);
    return 32'd10 * byte_width;
  endfunction

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// Beat storage for the stream FIFO: synchronous write port, asynchronous read port.
module axi_stream_fifo_mem
  import axi_stream_fifo_pkg::*;
#(
  parameter int unsigned addr_w = 4,
  parameter int unsigned data_w = 44
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [addr_w-1:0] wr_addr_i,
  input  logic [data_w-1:0] wr_data_i,
  input  logic [addr_w-1:0] rd_addr_i,
  output logic [data_w-1:0] rd_data_o
);

  logic [data_w-1:0] mem_q [2**addr_w];

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axi_stream_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO with word and complete-packet occupancy.
module axi_stream_fifo
  import axi_stream_fifo_pkg::*;
#(
  parameter int unsigned byte_width = 4,
  parameter int unsigned id_width   = 1,
  parameter int unsigned dest_width = 1,
  parameter int unsigned user_width = 1,
  parameter int unsigned depth_log2 = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [8*byte_width-1:0] s_axis_tdata,
  input  logic [byte_width-1:0]   s_axis_tstrb,
  input  logic [byte_width-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [id_width-1:0]     s_axis_tid,
  input  logic [dest_width-1:0]   s_axis_tdest,
  input  logic [user_width-1:0]   s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [8*byte_width-1:0] m_axis_tdata,
  output logic [byte_width-1:0]   m_axis_tstrb,
  output logic [byte_width-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [id_width-1:0]     m_axis_tid,
  output logic [dest_width-1:0]   m_axis_tdest,
  output logic [user_width-1:0]   m_axis_tuser,
  output logic [depth_log2:0]     word_count,
  output logic [depth_log2:0]     packet_count
);

  localparam int unsigned PTR_W    = depth_log2 + 32'd1;
  localparam int unsigned PAY_W    = axis_payload_w(byte_width, id_width, dest_width, user_width);
  localparam int unsigned STRB_LSB = axis_strb_lsb(byte_width);
  localparam int unsigned KEEP_LSB = axis_keep_lsb(byte_width);
  localparam int unsigned LAST_BIT = axis_last_bit(byte_width);
  localparam int unsigned ID_LSB   = LAST_BIT + 32'd1;
  localparam int unsigned DEST_LSB = ID_LSB + id_width;
  localparam int unsigned USER_LSB = DEST_LSB + dest_width;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [PAY_W-1:0] wr_payload_s;
  logic [PAY_W-1:0] rd_payload_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  assign full_s  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);

  // Ready is taken from registered state only, so a same-cycle pop never frees a full FIFO.
  assign s_axis_tready = !full_s && !reset;
  assign m_axis_tvalid = !empty_s;
  assign push_s        = s_axis_tvalid && s_axis_tready;
  assign pop_s         = m_axis_tvalid && m_axis_tready;

  assign wr_payload_s = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast,
                         s_axis_tkeep, s_axis_tstrb, s_axis_tdata};

  axi_stream_fifo_mem #(
    .addr_w (depth_log2),
    .data_w (PAY_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (push_s),
    .wr_addr_i (wr_ptr_q[PTR_W-2:0]),
    .wr_data_i (wr_payload_s),
    .rd_addr_i (rd_ptr_q[PTR_W-2:0]),
    .rd_data_o (rd_payload_s)
  );

  assign m_axis_tdata = rd_payload_s[STRB_LSB-1:0];
  assign m_axis_tstrb = rd_payload_s[KEEP_LSB-1:STRB_LSB];
  assign m_axis_tkeep = rd_payload_s[LAST_BIT-1:KEEP_LSB];
  assign m_axis_tlast = rd_payload_s[LAST_BIT];
  assign m_axis_tid   = rd_payload_s[DEST_LSB-1:ID_LSB];
  assign m_axis_tdest = rd_payload_s[USER_LSB-1:DEST_LSB];
  assign m_axis_tuser = rd_payload_s[PAY_W-1:USER_LSB];

  assign word_count   = wr_ptr_q - rd_ptr_q;
  assign packet_count = pkt_cnt_q;

  // Next pointer and packet-count values from this cycle's push/pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s && s_axis_tlast, pop_s && m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // State registers; reset discards every buffered beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Scoreboard bench for axi_stream_fifo (depth 4): queue model of accepted beats checked against the head.
module tb_axi_stream_fifo;

  localparam int BW       = 4;
  localparam int DL2      = 2;
  localparam int DEPTH    = 4;
  localparam int PW       = 10 * BW + 4;
  localparam int LAST_BIT = 10 * BW;

  logic clk = 1'b0;
  logic reset;
  logic s_valid, s_axis_tready;
  logic m_axis_tvalid, m_ready;
  logic [PW-1:0] s_beat, m_beat;
  logic [8*BW-1:0] m_tdata;
  logic [BW-1:0] m_tstrb, m_tkeep;
  logic m_tlast, m_tid, m_tdest, m_tuser;
  logic [DL2:0] word_count, packet_count;

  logic [PW-1:0] q[$];
  bit last_push;
  int n_pop = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_stream_fifo #(
    .byte_width(BW), .id_width(1), .dest_width(1), .user_width(1), .depth_log2(DL2)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_beat[31:0]), .s_axis_tstrb(s_beat[35:32]), .s_axis_tkeep(s_beat[39:36]),
    .s_axis_tlast(s_beat[40]), .s_axis_tid(s_beat[41]), .s_axis_tdest(s_beat[42]),
    .s_axis_tuser(s_beat[43]),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .word_count(word_count), .packet_count(packet_count)
  );

  assign m_beat = {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata};

  function automatic logic [PW-1:0] mk(input logic [31:0] d, input logic last);
    logic [2:0] side;
    logic [7:0] sk;
    side = 3'($urandom);
    sk   = 8'($urandom);
    return {side, last, sk, d};
  endfunction

  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i][LAST_BIT]) n++;
    return n;
  endfunction

  // One clock: predict accept/pop from model state, then update the model at the edge.
  task automatic tick();
    bit do_push, do_pop;
    do_push = s_valid && (q.size() < DEPTH) && !reset;
    do_pop  = m_ready && (q.size() != 0) && !reset;
    @(posedge clk);
    last_push = 1'b0;
    if (reset) begin
      q.delete();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (do_push) begin
        q.push_back(s_beat);
        last_push = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b1; m_ready = 1'b0; s_beat = mk(32'h1234_5678, 1'b1);
    tick(); tick();
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (word_count !== 3'd0) begin failures++; $display("FAIL rst_wc got=%0d exp=0", word_count); end
    checks++; if (packet_count !== 3'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", packet_count); end
    reset = 1'b0; s_valid = 1'b0;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL post_rst_tready got=%b exp=1", s_axis_tready); end
  endtask

  task automatic test_single();
    s_beat = mk(32'hDEAD_BEEF, 1'b1); s_valid = 1'b1; m_ready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%b exp=0", m_axis_tvalid); end
    tick();
    s_valid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL single_tvalid got=%b exp=1", m_axis_tvalid); end
    checks++; if (m_tdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_tdata got=%h exp=deadbeef", m_tdata); end
    checks++; if (q.size() != 1 || m_beat !== q[0]) begin failures++; $display("FAIL single_payload got=%h", m_beat); end
    checks++; if (word_count !== 3'd1) begin failures++; $display("FAIL single_wc got=%0d exp=1", word_count); end
    checks++; if (packet_count !== 3'd1) begin failures++; $display("FAIL single_pc got=%0d exp=1", packet_count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_pop_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (word_count !== 3'd0 || packet_count !== 3'd0) begin failures++; $display("FAIL single_pop_counts got=%0d/%0d exp=0/0", word_count, packet_count); end
  endtask

  task automatic test_fill();
    m_ready = 1'b0; s_valid = 1'b1; s_beat = mk($urandom, 1'($urandom));
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_axis_tready !== (q.size() < DEPTH)) begin failures++; $display("FAIL fill_tready[%0d] got=%b exp=%b", i, s_axis_tready, q.size() < DEPTH); end
      if (q.size() != 0) begin
        checks++; if (m_beat !== q[0]) begin failures++; $display("FAIL fill_stall_payload[%0d] got=%h exp=%h", i, m_beat, q[0]); end
      end
      tick();
      if (last_push) s_beat = mk($urandom, 1'($urandom));
    end
    checks++; if (word_count !== 3'd4) begin failures++; $display("FAIL fill_wc got=%0d exp=4", word_count); end
    checks++; if (packet_count !== 3'(model_pkts())) begin failures++; $display("FAIL fill_pc got=%0d exp=%0d", packet_count, model_pkts()); end
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL fill_full_tready got=%b exp=0", s_axis_tready); end
  endtask

  task automatic test_full_pop();
    s_valid = 1'b1; m_ready = 1'b1;
    checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL fullpop_tready got=%b exp=0", s_axis_tready); end
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    checks++; if (word_count !== 3'd3) begin failures++; $display("FAIL fullpop_wc got=%0d exp=3", word_count); end
    checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL fullpop_tready_next got=%b exp=1", s_axis_tready); end
    checks++; if (packet_count !== 3'(model_pkts())) begin failures++; $display("FAIL fullpop_pc got=%0d exp=%0d", packet_count, model_pkts()); end
    m_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      checks++; if (m_beat !== q[0]) begin failures++; $display("FAIL drain_payload[%0d] got=%h exp=%h", i, m_beat, q[0]); end
      tick();
    end
    m_ready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL drain_tvalid got=%b exp=0", m_axis_tvalid); end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; m_ready = 1'b1; s_beat = mk($urandom, 1'($urandom));
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_push) s_beat = mk($urandom, 1'($urandom));
      checks++; if (word_count !== 3'd1 || q.size() != 1) begin failures++; $display("FAIL b2b_wc[%0d] got=%0d exp=1", i, word_count); end
      checks++; if (q.size() == 0 || m_beat !== q[0]) begin failures++; $display("FAIL b2b_order[%0d] got=%h", i, m_beat); end
      checks++; if (packet_count !== 3'(model_pkts())) begin failures++; $display("FAIL b2b_pc[%0d] got=%0d exp=%0d", i, packet_count, model_pkts()); end
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL b2b_end_tvalid got=%b exp=0", m_axis_tvalid); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0; s_valid = 1'b1; s_beat = mk($urandom, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      s_beat = mk($urandom, 1'b1);
    end
    checks++; if (word_count !== 3'd3) begin failures++; $display("FAIL midrst_pre_wc got=%0d exp=3", word_count); end
    reset = 1'b1; s_valid = 1'b0;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (word_count !== 3'd0 || packet_count !== 3'd0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", word_count, packet_count); end
    reset = 1'b0; s_beat = mk(32'hCAFE_0001, 1'b0); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++; if (q.size() != 1 || m_beat !== q[0] || m_tdata !== 32'hCAFE_0001) begin failures++; $display("FAIL midrst_first got=%h", m_beat); end
    checks++; if (packet_count !== 3'd0) begin failures++; $display("FAIL midrst_pc got=%0d exp=0", packet_count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (word_count !== 3'd0) begin failures++; $display("FAIL midrst_drain_wc got=%0d exp=0", word_count); end
  endtask

  task automatic test_wrap();
    int n_sent = 0;
    int pop0 = n_pop;
    int cyc = 0;
    s_beat = mk($urandom, 1'($urandom));
    while ((n_pop - pop0) < 10 && cyc < 200) begin
      s_valid = (n_sent < 10);
      m_ready = cyc[0];
      checks++; if (word_count !== 3'(q.size()) || word_count > 3'd4) begin failures++; $display("FAIL wrap_wc[%0d] got=%0d exp=%0d", cyc, word_count, q.size()); end
      checks++; if (m_axis_tvalid !== (q.size() != 0)) begin failures++; $display("FAIL wrap_tvalid[%0d] got=%b", cyc, m_axis_tvalid); end
      if (q.size() != 0) begin
        checks++; if (m_beat !== q[0]) begin failures++; $display("FAIL wrap_payload[%0d] got=%h exp=%h", cyc, m_beat, q[0]); end
      end
      tick();
      if (last_push) begin
        n_sent++;
        s_beat = mk($urandom, 1'($urandom));
      end
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    checks++; if ((n_pop - pop0) != 10) begin failures++; $display("FAIL wrap_timeout popped=%0d exp=10", n_pop - pop0); end
    checks++; if (m_axis_tvalid !== 1'b0 || word_count !== 3'd0) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=0/0", m_axis_tvalid, word_count); end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_beat = '0;
    #1;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
